// File: rtl/bcd_serial_add.sv
// Digit-serial BCD adder: one shared decimal digit slice walks the latched
// operands least-significant digit first, one digit per clock.

// Single decimal digit add: binary sum, +6 correction when the result exceeds 9.
module bcd_digit_add (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       bad
);
  logic [4:0] raw;
  logic [4:0] adj;

  // raw sum, correction and invalid-digit flag
  always_comb begin
    raw  = {1'b0, x} + {1'b0, y} + {4'b0, cin};
    adj  = raw + 5'd6;
    cout = (raw > 5'd9);
    s    = cout ? adj[3:0] : raw[3:0];
    bad  = (x > 4'd9) || (y > 4'd9);
  end
endmodule

module bcd_serial_add #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  c_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  c_out,
  output logic                  err
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  a_q, b_q, res_q, res_nxt;
  logic [CW-1:0] cnt;
  logic          carry, err_q;
  logic [3:0]    x, y, dig;
  logic          dig_c, dig_bad, last;

  // Digit select and result merge use constant part-selects so the counter
  // width never has to match the operand index width.
  always_comb begin
    x       = '0;
    y       = '0;
    res_nxt = res_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt == CW'(i)) begin
        x                  = a_q[4*i +: 4];
        y                  = b_q[4*i +: 4];
        res_nxt[4*i +: 4]  = dig;
      end
    end
    last = (cnt == CW'(DIGITS - 1));
  end

  bcd_digit_add u_slice (
    .x    (x),
    .y    (y),
    .cin  (carry),
    .s    (dig),
    .cout (dig_c),
    .bad  (dig_bad)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state: start only honoured in IDLE, DONE lasts exactly one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // operand latch, digit iteration, and output load on the edge into DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      err_q <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_q   <= a;
          b_q   <= b;
          cnt   <= '0;
          carry <= c_in;
          err_q <= 1'b0;
        end
        RUN: begin
          res_q <= res_nxt;
          carry <= dig_c;
          err_q <= err_q | dig_bad;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum   <= res_nxt;
            c_out <= dig_c;
            err   <= err_q | dig_bad;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
endmodule
